// File: rtl/serial_word_receiver.sv
// ---------------------------------------------------------------------------
// SerialWordReceiver
//
// Purpose:
//   Assembles MSB-first serial bits into (WIDTH+1)-bit words. A frame begins
//   with a strobed bit that carries the 'first' marker. The word completes on
//   the edge that samples its (WIDTH+1)-th bit. It is then handed to a
//   one-entry output buffer with a valid/ready handshake.
//
//   Sticky flags report two error cases:
//     overrun  - a completed word was dropped because the buffer was full.
//     sync_err - a new frame marker arrived before the current frame finished.
//
// Ports:
//   clk       in   system clock; all state changes on the rising edge
//   res       in   asynchronous active-low reset
//   ser_in    in   serial data bit, MSB first
//   ser_en    in   bit strobe; ser_in/first are only looked at when high
//   first     in   frame marker, qualified by ser_en
//   ready     in   downstream accepts data_out when valid && ready
//   clr       in   synchronous clear of overrun and sync_err
//   data_out  out  assembled word, stable while valid && !ready
//   valid     out  data_out holds a word not yet accepted
//   busy      out  a frame is being shifted in
//   overrun   out  sticky: completed word dropped (buffer full)
//   sync_err  out  sticky: frame restarted mid-word, partial word lost
// ---------------------------------------------------------------------------
module serial_word_receiver #(
    parameter int WIDTH = 5
) (
    input  logic           clk,
    input  logic           res,
    input  logic           ser_in,
    input  logic           ser_en,
    input  logic           first,
    input  logic           ready,
    input  logic           clr,
    output logic [WIDTH:0] data_out,
    output logic           valid,
    output logic           busy,
    output logic           overrun,
    output logic           sync_err
);

    // The counter must be able to hold 0..WIDTH+1.
    localparam int CW = $clog2(WIDTH + 2);

    // Count value in SHIFT at the moment the final bit of a word is strobed.
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state;
    state_t         stateNext;
    logic [CW-1:0]  count;
    logic [CW-1:0]  countNext;
    logic [WIDTH:0] shiftReg;
    logic [WIDTH:0] shiftNext;
    logic           complete;
    logic [WIDTH:0] word;
    logic           syncSet;
    logic           overrunSet;

    // Next-state logic for the framing FSM.
    //
    // Bit placement: the k-th bit of a frame (k = 0 for the MSB) is written
    // at index WIDTH-k. The frame therefore fills from the MSB downwards, and
    // the final bit lands at index 0.
    //
    // 'word' is the fully assembled value, available on the completing edge.
    // The output buffer can then load it with no extra cycle of latency.
    always_comb begin
        stateNext = state;
        countNext = count;
        shiftNext = shiftReg;
        complete  = 1'b0;
        word      = shiftReg;
        syncSet   = 1'b0;

        unique case (state)
            IDLE: begin
                // Strobed bits without a frame marker are ignored here.
                if (ser_en && first) begin
                    shiftNext        = '0;
                    shiftNext[WIDTH] = ser_in;
                    if (WIDTH == 0) begin
                        // A one-bit word completes on its only bit.
                        complete  = 1'b1;
                        word      = shiftNext;
                        countNext = '0;
                    end else begin
                        countNext = CW'(1);
                        stateNext = SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (ser_en) begin
                    if (first) begin
                        // A marker arrived mid-frame: drop the partial word
                        // and restart with this bit as the new MSB.
                        syncSet          = 1'b1;
                        shiftNext        = '0;
                        shiftNext[WIDTH] = ser_in;
                        countNext        = CW'(1);
                    end else begin
                        for (int i = 0; i <= WIDTH; i++) begin
                            if (i == WIDTH - int'(count)) begin
                                shiftNext[i] = ser_in;
                            end
                        end
                        if (count == LAST_COUNT) begin
                            complete  = 1'b1;
                            word      = shiftNext;
                            countNext = '0;
                            stateNext = IDLE;
                        end else begin
                            countNext = count + 1'b1;
                        end
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Framing state, bit counter and partial-word register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state    <= IDLE;
            count    <= '0;
            shiftReg <= '0;
        end else begin
            state    <= stateNext;
            count    <= countNext;
            shiftReg <= shiftNext;
        end
    end

    // A completed word is lost only if the buffer is full and is not being
    // emptied on this same edge.
    assign overrunSet = complete && valid && !ready;

    // One-entry output buffer.
    //
    // A completed word may replace a word that is being accepted on the same
    // edge. Otherwise, an accepted word simply empties the buffer. data_out
    // keeps its last value after acceptance. valid depends only on registered
    // state, so there is no combinational path from ready to valid.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else if (complete) begin
            if (!valid || ready) begin
                data_out <= word;
                valid    <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    // Sticky error flags. A set event on the same edge as clr wins, so an
    // error occurring during a clear is never lost.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            overrun  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            overrun  <= overrunSet | (overrun & ~clr);
            sync_err <= syncSet | (sync_err & ~clr);
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_word_receiver.sv
// ---------------------------------------------------------------------------
// TbSerialWordReceiver
//
// Self-checking bench for serial_word_receiver at WIDTH=5.
//
// Structure:
//   - A driver runs directed scenarios followed by randomized traffic.
//   - A reference model holds the current frame as a queue of bits. When a
//     frame completes, its bits are turned into an integer word, and that
//     word is pushed onto an expected-word queue.
//   - A separate monitor compares data_out with the head of that queue
//     whenever valid is high, and pops the head on a handshake.
//   - The monitor also compares valid, busy, overrun and sync_err against
//     the model on every cycle.
// ---------------------------------------------------------------------------
module tb_serial_word_receiver;

    localparam int WIDTH = 5;

    logic           clk;
    logic           res;
    logic           serIn;
    logic           serEn;
    logic           firstIn;
    logic           readyIn;
    logic           clrIn;
    logic [WIDTH:0] dataOut;
    logic           validOut;
    logic           busyOut;
    logic           overrunOut;
    logic           syncErrOut;

    int compared = 0;
    int failed   = 0;

    // Reference model state, reflecting the DUT after the most recent edge.
    bit frameBits[$];
    bit inFrame;
    bit mValid;
    bit mOverrun;
    bit mSyncErr;
    int expQ[$];

    serial_word_receiver #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .res      (res),
        .ser_in   (serIn),
        .ser_en   (serEn),
        .first    (firstIn),
        .ready    (readyIn),
        .clr      (clrIn),
        .data_out (dataOut),
        .valid    (validOut),
        .busy     (busyOut),
        .overrun  (overrunOut),
        .sync_err (syncErrOut)
    );

    // Free-running clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Generic comparison used by both the driver and the monitor.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the model by one rising edge, using the inputs present at that
    // edge. The model works from the frame rules directly: collect bits,
    // then form a word once WIDTH+1 bits are present.
    task automatic modelEdge(input bit en, input bit f, input bit b, input bit r, input bit c);
        bit done;
        bit ovSet;
        bit seSet;
        int w;
        done  = 0;
        ovSet = 0;
        seSet = 0;
        w     = 0;
        if (en) begin
            if (f) begin
                if (inFrame) seSet = 1;
                frameBits.delete();
                frameBits.push_back(b);
                inFrame = 1;
            end else if (inFrame) begin
                frameBits.push_back(b);
            end
            if (inFrame && frameBits.size() == WIDTH + 1) begin
                foreach (frameBits[k]) w = w * 2 + int'(frameBits[k]);
                done = 1;
                frameBits.delete();
                inFrame = 0;
            end
        end
        if (done) begin
            if (!mValid || r) begin
                expQ.push_back(w);
                mValid = 1;
            end else begin
                ovSet = 1;
            end
        end else if (mValid && r) begin
            mValid = 0;
        end
        mOverrun = ovSet | (mOverrun & !c);
        mSyncErr = seSet | (mSyncErr & !c);
    endtask

    // Return the model to its reset state. Any buffered word is lost.
    task automatic modelReset();
        frameBits.delete();
        expQ.delete();
        inFrame  = 0;
        mValid   = 0;
        mOverrun = 0;
        mSyncErr = 0;
    endtask

    // Drive one cycle of inputs. Inputs change 1 time unit after a rising
    // edge and are held through the next edge. The model is updated just
    // after that edge.
    task automatic applyStimulus(input bit en, input bit f, input bit b, input bit r, input bit c);
        serEn   = en;
        firstIn = f;
        serIn   = b;
        readyIn = r;
        clrIn   = c;
        @(posedge clk);
        #1;
        modelEdge(en, f, b, r, c);
    endtask

    // Send a full framed word, MSB first. When gap is set, an idle cycle
    // follows each strobed bit. ready is low except on the final bit, where
    // it takes the value of readyLast.
    task automatic sendWord(input logic [WIDTH:0] w, input bit gap, input bit readyLast);
        logic [WIDTH:0] v;
        v = w;
        for (int i = WIDTH; i >= 0; i--) begin
            applyStimulus(1, i == WIDTH, v[i], (i == 0) ? readyLast : 1'b0, 0);
            if (gap && i != 0) applyStimulus(0, 0, 0, 0, 0);
        end
    endtask

    // Pulse reset mid-cycle and check that the outputs clear immediately,
    // without waiting for a clock edge.
    task automatic resetPulse();
        serEn = 0;
        res   = 0;
        modelReset();
        #1;
        checkOutput("rst data_out", 32'(dataOut), 0);
        checkOutput("rst valid", 32'(validOut), 0);
        checkOutput("rst busy", 32'(busyOut), 0);
        checkOutput("rst overrun", 32'(overrunOut), 0);
        checkOutput("rst sync_err", 32'(syncErrOut), 0);
        @(posedge clk);
        #1;
        res = 1;
    endtask

    // Monitor: scoreboard check of data_out plus a per-cycle flag check.
    initial begin
        forever begin
            @(negedge clk);
            if (res) begin
                checkOutput("mon valid", 32'(validOut), 32'(mValid));
                checkOutput("mon busy", 32'(busyOut), 32'(inFrame));
                checkOutput("mon overrun", 32'(overrunOut), 32'(mOverrun));
                checkOutput("mon sync_err", 32'(syncErrOut), 32'(mSyncErr));
                if (validOut) begin
                    if (expQ.size() == 0) begin
                        compared++;
                        failed++;
                        $display("[TB] FAIL mon underflow: valid=1 with data %0h, expected no word at %0t", dataOut, $time);
                    end else begin
                        checkOutput("mon data_out", 32'(dataOut), 32'(expQ[0]));
                        if (readyIn) void'(expQ.pop_front());
                    end
                end
            end
        end
    end

    // Driver: directed scenarios, then randomized traffic.
    initial begin
        res     = 0;
        serIn   = 0;
        serEn   = 0;
        firstIn = 0;
        readyIn = 0;
        clrIn   = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset valid", 32'(validOut), 0);
        checkOutput("reset data_out", 32'(dataOut), 0);
        checkOutput("reset busy", 32'(busyOut), 0);
        res = 1;

        // Basic word with ready low.
        sendWord(6'b100011, 0, 0);
        checkOutput("basic data_out", 32'(dataOut), 32'h23);
        checkOutput("basic valid", 32'(validOut), 1);
        checkOutput("basic busy", 32'(busyOut), 0);
        applyStimulus(0, 0, 0, 1, 0);

        // Same word with the strobe toggling between bits.
        sendWord(6'b100011, 1, 0);
        checkOutput("gapped data_out", 32'(dataOut), 32'h23);
        checkOutput("gapped valid", 32'(validOut), 1);

        // Overrun: buffer still full when the second word completes.
        sendWord(6'b010101, 0, 0);
        checkOutput("overrun data_out", 32'(dataOut), 32'h23);
        checkOutput("overrun flag", 32'(overrunOut), 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("overrun drain valid", 32'(validOut), 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("overrun clr", 32'(overrunOut), 0);

        // Back-to-back words, second completes on the edge where the first
        // is accepted.
        sendWord(6'b110010, 0, 0);
        sendWord(6'b001101, 0, 1);
        checkOutput("b2b data_out", 32'(dataOut), 32'h0D);
        checkOutput("b2b valid", 32'(validOut), 1);
        checkOutput("b2b overrun", 32'(overrunOut), 0);
        applyStimulus(0, 0, 0, 1, 0);

        // Frame restarted after three bits.
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        sendWord(6'b111111, 0, 0);
        checkOutput("sync sync_err", 32'(syncErrOut), 1);
        checkOutput("sync data_out", 32'(dataOut), 32'h3F);
        checkOutput("sync valid", 32'(validOut), 1);
        applyStimulus(0, 0, 0, 1, 1);

        // Reset after four bits, unframed bits ignored, then a clean word.
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        resetPulse();
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("post-reset busy", 32'(busyOut), 0);
        sendWord(6'b101101, 0, 0);
        checkOutput("post-reset data_out", 32'(dataOut), 32'h2D);
        applyStimulus(0, 0, 0, 1, 0);

        // Randomized traffic, with an occasional reset pulse.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                resetPulse();
            end else begin
                applyStimulus($urandom_range(0, 3) != 0,
                              $urandom_range(0, 9) == 0,
                              1'($urandom_range(0, 1)),
                              $urandom_range(0, 2) == 0,
                              $urandom_range(0, 19) == 0);
            end
        end

        // Drain the buffer and confirm every expected word was seen.
        repeat (4) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("final queue empty", 32'(expQ.size()), 0);
        checkOutput("final valid", 32'(validOut), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
